// File: rtl/tinyriscv_pkg.sv
// rtl/tinyriscv_pkg.sv - shared bus widths, pipeline hold codes and fetch types
package tinyriscv_pkg;

  localparam int InstAddrBus   = 32;
  localparam int InstBus       = 32;
  localparam int Hold_Flag_Bus = 3;

  localparam logic [Hold_Flag_Bus-1:0] Pipe_Flow  = 3'd0;
  localparam logic [Hold_Flag_Bus-1:0] Pipe_Clear = 3'd1;
  localparam logic [Hold_Flag_Bus-1:0] Pipe_Stall = 3'd2;

  localparam logic [InstAddrBus-1:0] CpuResetAddr = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [InstBus-1:0]     inst;
    logic [InstAddrBus-1:0] addr;
  } fetch_entry_t;

  localparam int EntryW = $bits(fetch_entry_t);

endpackage

// File: rtl/if_prefetch_fifo.sv
// rtl/if_prefetch_fifo.sv - registered prefetch FIFO of fetch entries with flush
module if_prefetch_fifo
  import tinyriscv_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push,
  input  logic [EntryW-1:0]           entry,
  input  logic                        pop,
  input  logic                        flush,
  output logic [EntryW-1:0]           head,
  output logic [$clog2(Depth):0]      count,
  output logic                        empty
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth) + 1;

  logic [EntryW-1:0] mem [Depth];
  logic [PtrW-1:0]   rd_ptr;
  logic [PtrW-1:0]   wr_ptr;
  logic [CntW-1:0]   cnt;
  logic              do_push;
  logic              do_pop;

  assign empty   = (cnt == '0);
  assign do_push = push && (cnt != CntW'(Depth));
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      cnt <= cnt + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction fetch front end with prefetch FIFO
// Optional saturating perf counters are built when IF_PREFETCH_PERF_EN is defined.
module if_prefetch
  import tinyriscv_pkg::*;
#(
  parameter int                     Depth   = 2,
  parameter logic [InstAddrBus-1:0] ResetPc = CpuResetAddr
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     jump_flag_i,
  input  logic [InstAddrBus-1:0]   jump_addr_i,
  input  logic [Hold_Flag_Bus-1:0] hold_flag_i,
  output logic                     ibus_req_o,
  output logic [InstAddrBus-1:0]   ibus_addr_o,
  input  logic                     ibus_gnt_i,
  input  logic                     ibus_rvalid_i,
  input  logic [InstBus-1:0]       ibus_rdata_i,
  output logic                     inst_valid_o,
  output logic [InstBus-1:0]       inst_o,
  output logic [InstAddrBus-1:0]   inst_addr_o,
  input  logic                     inst_ready_i,
  output logic [31:0]              perf_discard_o,
  output logic [31:0]              perf_starve_o
);

  localparam int CntW = $clog2(Depth) + 1;

  fetch_state_e           state_q, state_d;
  logic [InstAddrBus-1:0] fetch_pc_q, deliver_pc_q, resp_pc_q, jump_tgt;
  logic [CntW-1:0]        outstanding_q, discard_q, fifo_count;
  fetch_entry_t           fifo_head, fifo_push_entry;
  logic                   fifo_empty;
  logic                   flow, clear, kill, grant, pop, drop, push, req, valid;

  assign flow     = (hold_flag_i == Pipe_Flow);
  assign clear    = (hold_flag_i == Pipe_Clear);
  assign kill     = jump_flag_i || clear;
  assign jump_tgt = jump_addr_i & ~InstAddrBus'(3);

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    valid   = 1'b0;
    if (clear && !jump_flag_i) begin
      state_d = HALT;
    end else if (!clear) begin
      state_d = RUN;
    end
    if (!rst_i && state_q == RUN && flow && !jump_flag_i) begin
      req   = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CntW+1)'(Depth);
      valid = !fifo_empty;
    end
  end

  assign grant = req && ibus_gnt_i;
  assign pop   = valid && inst_ready_i;
  // Anything arriving during a redirect, or owed to an earlier one, is stale.
  assign drop  = ibus_rvalid_i && (kill || discard_q != '0);
  assign push  = ibus_rvalid_i && !drop;

  assign fifo_push_entry = '{inst: ibus_rdata_i, addr: resp_pc_q};

  assign ibus_req_o   = req;
  assign ibus_addr_o  = req ? fetch_pc_q : '0;
  assign inst_valid_o = valid;
  assign inst_o       = fifo_empty ? '0 : fifo_head.inst;
  assign inst_addr_o  = fifo_empty ? '0 : fifo_head.addr;

  if_prefetch_fifo #(
    .Depth(Depth)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .entry (fifo_push_entry),
    .pop   (pop),
    .flush (kill),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // resp_pc tracks the address of the next non-stale response to arrive.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q    <= ResetPc;
      deliver_pc_q  <= ResetPc;
      resp_pc_q     <= ResetPc;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_q + CntW'(grant) - CntW'(ibus_rvalid_i);
      if (kill) begin
        discard_q <= outstanding_q - CntW'(ibus_rvalid_i);
      end else if (drop) begin
        discard_q <= discard_q - CntW'(1);
      end
      if (jump_flag_i) begin
        fetch_pc_q   <= jump_tgt;
        deliver_pc_q <= jump_tgt;
        resp_pc_q    <= jump_tgt;
      end else if (clear) begin
        fetch_pc_q <= deliver_pc_q;
        resp_pc_q  <= deliver_pc_q;
      end else begin
        if (grant) fetch_pc_q   <= fetch_pc_q + InstAddrBus'(4);
        if (pop)   deliver_pc_q <= deliver_pc_q + InstAddrBus'(4);
        if (push)  resp_pc_q    <= resp_pc_q + InstAddrBus'(4);
      end
    end
  end

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_discard_q, perf_starve_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_discard_q <= '0;
      perf_starve_q  <= '0;
    end else begin
      if (drop && perf_discard_q != '1) begin
        perf_discard_q <= perf_discard_q + 32'd1;
      end
      if (inst_ready_i && !valid && state_q == RUN && perf_starve_q != '1) begin
        perf_starve_q <= perf_starve_q + 32'd1;
      end
    end
  end

  assign perf_discard_o = perf_discard_q;
  assign perf_starve_o  = perf_starve_q;
`else
  assign perf_discard_o = '0;
  assign perf_starve_o  = '0;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - randomized scoreboard bench for if_prefetch
module tb_if_prefetch;
  import tinyriscv_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = CpuResetAddr;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } pend_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic [2:0]  hold_flag_i = Pipe_Flow;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] perf_discard_o;
  logic [31:0] perf_starve_o;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  int          epoch = 0;
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] m_deliver_pc = RESET_PC;
  bit          m_halt = 1'b0;
  int          m_disc = 0;
  int          m_starve = 0;
  int          n_deliver = 0;
  int          n_checks = 0;
  int          n_err = 0;
  int          gnt_pct = 100;
  int          rv_pct = 100;

  if_prefetch dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .jump_flag_i    (jump_flag_i),
    .jump_addr_i    (jump_addr_i),
    .hold_flag_i    (hold_flag_i),
    .ibus_req_o     (ibus_req_o),
    .ibus_addr_o    (ibus_addr_o),
    .ibus_gnt_i     (ibus_gnt_i),
    .ibus_rvalid_i  (ibus_rvalid_i),
    .ibus_rdata_i   (ibus_rdata_i),
    .inst_valid_o   (inst_valid_o),
    .inst_o         (inst_o),
    .inst_addr_o    (inst_addr_o),
    .inst_ready_i   (inst_ready_i),
    .perf_discard_o (perf_discard_o),
    .perf_starve_o  (perf_starve_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queue.
  initial begin
    bit exp_req;
    bit exp_valid;
    forever begin
      @(negedge clk_i);
      #1;
      if (rst_i) begin
        chk("rst_req", 32'(ibus_req_o), 0);
        chk("rst_valid", 32'(inst_valid_o), 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_inst_addr", inst_addr_o, RESET_PC);
        chk("rst_perf_discard", perf_discard_o, 0);
        chk("rst_perf_starve", perf_starve_o, 0);
      end else begin
        exp_req = !m_halt && hold_flag_i == Pipe_Flow && !jump_flag_i &&
                  (int'(exp_q.size()) + int'(pend_q.size()) < DEPTH);
        exp_valid = !m_halt && hold_flag_i == Pipe_Flow && !jump_flag_i &&
                    exp_q.size() != 0;
        chk("ibus_req", 32'(ibus_req_o), 32'(exp_req));
        chk("inst_valid", 32'(inst_valid_o), 32'(exp_valid));
        if (exp_q.size() == 0) begin
          chk("empty_inst", inst_o, 0);
          chk("empty_inst_addr", inst_addr_o, 0);
        end else begin
          chk("head_addr", inst_addr_o, exp_q[0].addr);
          chk("head_inst", inst_o, exp_q[0].inst);
          chk("deliver_pc", inst_addr_o, m_deliver_pc);
        end
        if (inst_valid_o && inst_ready_i && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          m_deliver_pc += 32'd4;
          n_deliver++;
        end
        if (inst_ready_i && !inst_valid_o && !m_halt) m_starve++;
      end
    end
  end

  // One clock of stimulus plus bus behaviour, then the reference model update.
  task automatic step(input logic [2:0] h, input logic j, input logic [31:0] ja,
                      input logic r, input logic rs);
    pend_t       p;
    bit          kill;
    logic [31:0] tgt;
    @(negedge clk_i);
    rst_i        = rs;
    hold_flag_i  = h;
    jump_flag_i  = j;
    jump_addr_i  = ja;
    inst_ready_i = r;
    ibus_gnt_i   = !rs && ($urandom_range(99) < gnt_pct);
    if (!rs && pend_q.size() != 0 && $urandom_range(99) < rv_pct) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = word_at(pend_q[0].addr);
    end else begin
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = $urandom;
    end
    #2;
    if (rs) begin
      exp_q.delete();
      pend_q.delete();
      m_fetch_pc   = RESET_PC;
      m_deliver_pc = RESET_PC;
      m_halt       = 1'b0;
      m_disc       = 0;
      m_starve     = 0;
    end else begin
      kill = j || h == Pipe_Clear;
      if (ibus_rvalid_i) begin
        p = pend_q.pop_front();
        if (kill || p.epoch != epoch) m_disc++;
        else exp_q.push_back('{addr: p.addr, inst: word_at(p.addr)});
      end
      if (ibus_req_o && ibus_gnt_i) begin
        chk("req_addr", ibus_addr_o, m_fetch_pc);
        pend_q.push_back('{addr: m_fetch_pc, epoch: epoch});
        m_fetch_pc += 32'd4;
      end
      if (kill) begin
        exp_q.delete();
        epoch++;
        if (j) begin
          tgt          = ja & ~32'd3;
          m_fetch_pc   = tgt;
          m_deliver_pc = tgt;
        end else begin
          m_fetch_pc = m_deliver_pc;
        end
      end
      if (h == Pipe_Clear && !j) m_halt = 1'b1;
      else if (h != Pipe_Clear) m_halt = 1'b0;
    end
  endtask

  task automatic run(input int n, input logic [2:0] h, input logic r);
    for (int k = 0; k < n; k++) step(h, 1'b0, 32'h0, r, 1'b0);
  endtask

  initial begin
    logic [2:0]  h;
    logic [31:0] ja;
    int          rr;
    // reset held with Pipe_Flow on the hold code
    step(Pipe_Flow, 1'b0, 32'h0, 1'b1, 1'b1);
    step(Pipe_Flow, 1'b0, 32'h0, 1'b1, 1'b1);
    // streaming with full-rate grants and single-cycle response
    gnt_pct = 100; rv_pct = 100;
    run(12, Pipe_Flow, 1'b1);
    // back-pressure from IF/ID, then resume
    run(10, Pipe_Flow, 1'b0);
    run(6, Pipe_Flow, 1'b1);
    // build two outstanding requests, then redirect to 0x100
    rv_pct = 0;
    run(3, Pipe_Flow, 1'b0);
    step(Pipe_Flow, 1'b1, 32'h100, 1'b0, 1'b0);
    rv_pct = 100;
    run(10, Pipe_Flow, 1'b1);
    // fill FIFO at 0x20/0x24, then Pipe_Clear for 5 cycles and refetch
    step(Pipe_Flow, 1'b1, 32'h20, 1'b0, 1'b0);
    run(6, Pipe_Flow, 1'b0);
    run(5, Pipe_Clear, 1'b1);
    run(10, Pipe_Flow, 1'b1);
    // stall with a response in flight
    rv_pct = 0;
    run(1, Pipe_Flow, 1'b0);
    rv_pct = 100;
    run(3, Pipe_Stall, 1'b1);
    run(6, Pipe_Flow, 1'b1);
    // jump concurrent with rvalid, misaligned target
    run(3, Pipe_Flow, 1'b1);
    step(Pipe_Flow, 1'b1, 32'h102, 1'b1, 1'b0);
    run(8, Pipe_Flow, 1'b1);
    // reset mid-burst
    run(3, Pipe_Flow, 1'b1);
    step(Pipe_Flow, 1'b0, 32'h0, 1'b1, 1'b1);
    run(8, Pipe_Flow, 1'b1);
    chk("directed_progress", 32'(n_deliver >= 10), 1);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        gnt_pct = 30 + int'($urandom_range(70));
        rv_pct  = 30 + int'($urandom_range(70));
      end
      rr = int'($urandom_range(99));
      h  = (rr < 75) ? Pipe_Flow : (rr < 92) ? Pipe_Stall : Pipe_Clear;
      ja = $urandom_range(1) ? $urandom : 32'($urandom_range(255));
      step(h, $urandom_range(99) < 4, ja, $urandom_range(99) < 70, i == 300);
    end
    gnt_pct = 100; rv_pct = 100;
    run(10, Pipe_Flow, 1'b1);
    @(posedge clk_i);
    #1;
    chk("total_progress", 32'(n_deliver >= 40), 1);
`ifdef IF_PREFETCH_PERF_EN
    chk("perf_discard", perf_discard_o, m_disc);
    chk("perf_starve", perf_starve_o, m_starve);
`else
    chk("perf_discard", perf_discard_o, 0);
    chk("perf_starve", perf_starve_o, 0);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
